multicycle_param_processor: RTL and testbench

Parametrised multi-cycle successor to the 8-bit single-cycle processor. It provides:
- configurable data width, register count and program depth;
- a five-function ALU with a zero flag;
- unconditional jump, branch-if-zero and halt;
- load ports that write the instruction memory and register file while the core is idle.

The block sits under the Tiny Tapeout top wrapper and drives the user outputs from `result`.

---
 rtl/multicycle_param_processor_if.sv | 33 +++
 rtl/multicycle_param_processor.sv | 158 +++++++++++++++
 tb/tb_multicycle_param_processor.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_param_processor_if.sv
// Load, control and status bundle of the multi-cycle processor.
// The core takes the slave side and the loader/sequencer takes the master side.
interface multicycle_param_processor_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4
);
  localparam int INSTR_W = 3 + 3 * REG_AW;

  logic               start;
  logic               imem_we;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               reg_we;
  logic [REG_AW-1:0]  reg_addr;
  logic [DATA_W-1:0]  reg_data;
  logic               busy;
  logic               done;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  result;
  logic               zero;

  modport master (
    output start, imem_we, imem_addr, imem_data, reg_we, reg_addr, reg_data,
    input  busy, done, pc, instr, result, zero
  );

  modport slave (
    input  start, imem_we, imem_addr, imem_data, reg_we, reg_addr, reg_data,
    output busy, done, pc, instr, result, zero
  );
endinterface

// File: rtl/multicycle_param_processor.sv
// Parametrised two-cycle-per-instruction processor: FETCH loads the IR, EXEC retires it.
// Instruction memory and register file are writable from outside only while IDLE.
module multicycle_param_processor #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_param_processor_if.slave bus
);
  localparam int INSTR_W    = 3 + 3 * REG_AW;
  localparam int N_REGS     = 1 << REG_AW;
  localparam int IMEM_DEPTH = 1 << PC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_BZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic [1:0]         state_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               zero_reg;
  logic               done_reg;

  logic [DATA_W-1:0]  reg_q  [N_REGS];
  logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

  logic               is_idle;
  logic               exec_alu;
  logic [2:0]         op;
  logic [REG_AW-1:0]  rs1;
  logic [REG_AW-1:0]  rs2;
  logic [REG_AW-1:0]  rd;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc_inc;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  alu_value;

  assign is_idle  = (state_reg == S_IDLE);
  assign op       = ir_reg[INSTR_W-1 -: 3];
  assign rs1      = ir_reg[3*REG_AW-1 -: REG_AW];
  assign rs2      = ir_reg[2*REG_AW-1 -: REG_AW];
  assign rd       = ir_reg[REG_AW-1:0];
  assign target   = ir_reg[PC_W-1:0];
  assign pc_inc   = pc_reg + PC_W'(1);
  assign exec_alu = (state_reg == S_EXEC) && (op <= OP_XOR);

  // Operands come from the registered file, so rd == rs1/rs2 sees pre-write values.
  assign op_a = reg_q[rs1];
  assign op_b = reg_q[rs2];

  always_comb begin
    alu_value = '0;
    case (op)
      OP_ADD:  alu_value = op_a + op_b;
      OP_SUB:  alu_value = op_a - op_b;
      OP_AND:  alu_value = op_a & op_b;
      OP_OR:   alu_value = op_a | op_b;
      OP_XOR:  alu_value = op_a ^ op_b;
      default: alu_value = '0;
    endcase
  end

  genvar gi;

  // Register file: cleared on reset, written by EXEC of an ALU op or by an IDLE load.
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_regs
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (exec_alu && rd == REG_AW'(gi)) begin
          word_reg <= alu_value;
        end else if (is_idle && bus.reg_we && bus.reg_addr == REG_AW'(gi)) begin
          word_reg <= bus.reg_data;
        end
      end
      assign reg_q[gi] = word_reg;
    end
  endgenerate

  // Instruction memory resets to all-ones so an unloaded program halts at once.
  generate
    for (gi = 0; gi < IMEM_DEPTH; gi++) begin : g_imem
      logic [INSTR_W-1:0] word_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '1;
        end else if (is_idle && bus.imem_we && bus.imem_addr == PC_W'(gi)) begin
          word_reg <= bus.imem_data;
        end
      end
      assign imem_q[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      ir_reg     <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg <= S_FETCH;
            pc_reg    <= '0;
          end
        end
        S_FETCH: begin
          ir_reg    <= imem_q[pc_reg];
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          state_reg <= S_FETCH;
          case (op)
            OP_JMP:  pc_reg <= target;
            OP_BZ:   pc_reg <= zero_reg ? target : pc_inc;
            OP_HALT: begin
              state_reg <= S_IDLE;
              done_reg  <= 1'b1;
            end
            default: begin
              pc_reg     <= pc_inc;
              result_reg <= alu_value;
              zero_reg   <= (alu_value == '0);
            end
          endcase
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_reg == S_FETCH) || (state_reg == S_EXEC);
  assign bus.done   = done_reg;
  assign bus.pc     = pc_reg;
  assign bus.instr  = ir_reg;
  assign bus.result = result_reg;
  assign bus.zero   = zero_reg;
endmodule

// File: tb/tb_multicycle_param_processor.sv
// Self-checking bench: directed and random programs compared against an
// instruction-level interpreter of the processor's architectural behaviour.
module tb_multicycle_param_processor;
  logic clk;
  logic rst_n;

  multicycle_param_processor_if #(.DATA_W(8), .REG_AW(2), .PC_W(4)) bus ();

  multicycle_param_processor #(.DATA_W(8), .REG_AW(2), .PC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  int m_imem [16];
  int m_regs [4];
  int m_pc;
  int m_result;
  bit m_zero;

  // Interpret the program from pc 0 until HALT; returns instructions retired (HALT included).
  function automatic int model_run();
    int p = 0;
    int n = 0;
    while (n < 1000) begin
      int w, op, a, b, d, x, y, v;
      w  = m_imem[p];
      op = w / 64;
      a  = (w / 16) % 4;
      b  = (w / 4) % 4;
      d  = w % 4;
      x  = m_regs[a];
      y  = m_regs[b];
      n++;
      if (op == 7) break;
      else if (op == 5) p = w % 16;
      else if (op == 6) p = m_zero ? (w % 16) : (p + 1) % 16;
      else begin
        case (op)
          0:       v = (x + y) % 256;
          1:       v = (x - y + 256) % 256;
          2:       v = x & y;
          3:       v = x | y;
          default: v = x ^ y;
        endcase
        m_regs[d] = v;
        m_result  = v;
        m_zero    = (v == 0);
        p = (p + 1) % 16;
      end
    end
    m_pc = p;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_imem[i] = 'h1FF;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0;
    m_result = 0;
    m_zero = 0;
  endfunction

  function automatic void model_preload();
    for (int i = 0; i < 16; i++) m_imem[i] = 'h1FF;
    m_regs[0] = 'hAA;
    m_regs[1] = 'h1A;
    m_regs[2] = 'h33;
    m_regs[3] = 'hDD;
  endfunction

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.imem_we   = 1'b0;
    bus.imem_addr = '0;
    bus.imem_data = '0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_data  = '0;
  endtask

  // Writes the whole model image; registers load alongside the first four words.
  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.imem_we   = 1'b1;
      bus.imem_addr = 4'(i);
      bus.imem_data = 9'(m_imem[i]);
      bus.reg_we    = (i < 4);
      bus.reg_addr  = 2'(i);
      bus.reg_data  = 8'(m_regs[i % 4]);
      @(posedge clk);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic load_word(input int addr, input int data);
    @(negedge clk);
    bus.imem_we   = 1'b1;
    bus.imem_addr = 4'(addr);
    bus.imem_data = 9'(data);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  // Pulses start and counts rising edges from the start edge until done is seen.
  task automatic run_program(input bit disturb, input bit load0, input int w0,
                             output int cycles, output bit timed_out);
    @(negedge clk);
    bus.start = 1'b1;
    if (load0) begin
      bus.imem_we   = 1'b1;
      bus.imem_addr = '0;
      bus.imem_data = 9'(w0);
    end
    @(posedge clk);
    cycles = -1;
    timed_out = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.done) begin
        cycles = k - 1;
        timed_out = 1'b0;
        clear_inputs();
        break;
      end
      if (disturb) begin
        bus.start     = 1'b1;
        bus.imem_we   = 1'b1;
        bus.imem_addr = 4'($urandom_range(0, 15));
        bus.imem_data = 9'($urandom_range(0, 511));
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 2'($urandom_range(0, 3));
        bus.reg_data  = 8'($urandom_range(0, 255));
      end else begin
        clear_inputs();
      end
      @(posedge clk);
    end
    clear_inputs();
    $display("run: disturb=%0b cycles=%0d pc=%0d result=%02h zero=%0b", disturb, cycles,
             bus.pc, bus.result, bus.zero);
  endtask

  // Reads register i through the datapath with OR ri,ri->ri; HALT.
  task automatic read_reg(input int i, output int v);
    int cyc, n;
    bit to;
    m_imem[0] = 192 + 21 * i;
    m_imem[1] = 'h1FF;
    load_word(0, m_imem[0]);
    load_word(1, m_imem[1]);
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    v = to ? -1 : int'(bus.result);
  endtask

  task automatic test_reset();
    int cyc, n;
    bit to;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.pc, bus.instr, bus.result, bus.zero, bus.busy, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%0d ir=%03h res=%02h z=%0b busy=%0b done=%0b, expected all 0",
               bus.pc, bus.instr, bus.result, bus.zero, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n) begin
      n_fail++;
      $display("FAIL reset_halt_cycles: got %0d expected %0d", cyc, 2 * n);
    end
  endtask

  task automatic test_add();
    int cyc, n, v;
    bit to;
    model_preload();
    m_imem[0] = 'h006;
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n) begin
      n_fail++;
      $display("FAIL add_cycles: got %0d expected %0d", cyc, 2 * n);
    end
    n_checks++;
    if ({bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
      n_fail++;
      $display("FAIL add_state: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
               bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL add_done_pulse: got done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
    end
    read_reg(2, v);
    n_checks++;
    if (v !== m_regs[2]) begin
      n_fail++;
      $display("FAIL add_r2: got %02h expected %02h", v, m_regs[2]);
    end
  endtask

  task automatic test_overflow();
    int cyc, n;
    bit to;
    model_preload();
    m_imem[0] = 'h00F;
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || {bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
      n_fail++;
      $display("FAIL overflow_state: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
               bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
    end
  endtask

  task automatic test_bz();
    int cyc, n;
    bit to;
    model_preload();
    m_imem[0] = 'h057;
    m_imem[1] = 'h185;
    for (int i = 2; i < 5; i++) m_imem[i] = $urandom_range(0, 4) * 64 + $urandom_range(0, 63);
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n) begin
      n_fail++;
      $display("FAIL bz_cycles: got %0d expected %0d", cyc, 2 * n);
    end
    n_checks++;
    if ({bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
      n_fail++;
      $display("FAIL bz_state: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
               bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
    end
  endtask

  task automatic test_jmp();
    int cyc, n, v;
    int exp_regs [4];
    bit to;
    model_preload();
    m_imem[0] = 'h143;
    m_imem[1] = 'h104;
    m_imem[2] = 'h006;
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n || bus.pc !== 4'(m_pc)) begin
      n_fail++;
      $display("FAIL jmp_flow: got cycles=%0d pc=%0d expected cycles=%0d pc=%0d", cyc, bus.pc, 2 * n, m_pc);
    end
    exp_regs = m_regs;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_checks++;
      if (v !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL jmp_reg%0d: got %02h expected %02h", i, v, exp_regs[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, n;
    bit to;
    model_preload();
    m_regs[1] = 1;
    m_regs[2] = 2;
    m_imem[0] = 'h040;
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || bus.zero !== m_zero) begin
      n_fail++;
      $display("FAIL wrap_setup_zero: got %0b expected %0b", bus.zero, m_zero);
    end
    for (int i = 0; i < 16; i++) m_imem[i] = 'h01B;
    m_imem[0] = 'h184;
    m_imem[2] = 'h1FF;
    load_all();
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n) begin
      n_fail++;
      $display("FAIL wrap_cycles: got %0d expected %0d", cyc, 2 * n);
    end
    n_checks++;
    if ({bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
      n_fail++;
      $display("FAIL wrap_state: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
               bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, n, v;
    bit to;
    for (int i = 0; i < 16; i++) m_imem[i] = 'h1FF;
    for (int i = 0; i < 6; i++) m_imem[i] = $urandom_range(0, 4) * 64 + $urandom_range(0, 63);
    for (int i = 0; i < 4; i++) m_regs[i] = $urandom_range(0, 255);
    load_all();
    for (int pass = 0; pass < 2; pass++) begin
      run_program(pass == 0, 1'b0, 0, cyc, to);
      n = model_run();
      n_checks++;
      if (to || cyc !== 2 * n) begin
        n_fail++;
        $display("FAIL busy_cycles%0d: got %0d expected %0d", pass, cyc, 2 * n);
      end
      n_checks++;
      if ({bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
        n_fail++;
        $display("FAIL busy_state%0d: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
                 pass, bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int e;
      e = m_regs[i];
      read_reg(i, v);
      n_checks++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL busy_reg%0d: got %02h expected %02h", i, v, e);
      end
    end
  endtask

  task automatic test_load_with_start();
    int cyc, n;
    bit to;
    model_preload();
    load_all();
    m_imem[0] = 'h018;
    run_program(1'b0, 1'b1, m_imem[0], cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n || bus.result !== 8'(m_result)) begin
      n_fail++;
      $display("FAIL load_start: got cycles=%0d res=%02h expected cycles=%0d res=%02h",
               cyc, bus.result, 2 * n, m_result);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n, v;
    bit to;
    model_preload();
    m_imem[0] = 'h006;
    load_all();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.instr} !== {1'b1, 9'h006}) begin
      n_fail++;
      $display("FAIL midreset_in_exec: got busy=%0b ir=%03h expected 1 006", bus.busy, bus.instr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pc, bus.instr, bus.result, bus.zero, bus.busy, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got pc=%0d ir=%03h res=%02h z=%0b busy=%0b done=%0b, expected all 0",
               bus.pc, bus.instr, bus.result, bus.zero, bus.busy, bus.done);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_program(1'b0, 1'b0, 0, cyc, to);
    n = model_run();
    n_checks++;
    if (to || cyc !== 2 * n || bus.pc !== 4'(m_pc)) begin
      n_fail++;
      $display("FAIL midreset_halt: got cycles=%0d pc=%0d expected cycles=%0d pc=%0d", cyc, bus.pc, 2 * n, m_pc);
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_checks++;
      if (v !== 0) begin
        n_fail++;
        $display("FAIL midreset_reg%0d: got %02h expected 00", i, v);
      end
    end
  endtask

  // Random programs; branches only go forward so every program reaches a HALT.
  task automatic test_random();
    int cyc, n;
    bit to;
    for (int it = 0; it < 10; it++) begin
      for (int p = 0; p < 15; p++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) m_imem[p] = $urandom_range(0, 4) * 64 + $urandom_range(0, 63);
        else if (r == 7) m_imem[p] = 5 * 64 + $urandom_range(0, 3) * 16 + $urandom_range(p + 1, 15);
        else if (r == 8) m_imem[p] = 6 * 64 + $urandom_range(0, 3) * 16 + $urandom_range(p + 1, 15);
        else m_imem[p] = 7 * 64 + $urandom_range(0, 63);
      end
      m_imem[15] = 'h1FF;
      for (int i = 0; i < 4; i++) m_regs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      load_all();
      run_program(1'b0, 1'b0, 0, cyc, to);
      n = model_run();
      n_checks++;
      if (to || cyc !== 2 * n) begin
        n_fail++;
        $display("FAIL random%0d_cycles: got %0d expected %0d", it, cyc, 2 * n);
      end
      n_checks++;
      if ({bus.pc, bus.result, bus.zero} !== {4'(m_pc), 8'(m_result), m_zero}) begin
        n_fail++;
        $display("FAIL random%0d_state: got pc=%0d res=%02h z=%0b expected pc=%0d res=%02h z=%0b",
                 it, bus.pc, bus.result, bus.zero, m_pc, m_result, m_zero);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_bz();
    test_jmp();
    test_wrap();
    test_busy_ignore();
    test_load_with_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
